// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V instruction decode between IFU and EXU.
//
// Decodes opcode, funct3/funct7, register indices and the sign-extended
// immediate for all base formats. It classifies the format (R=0 I=1 S=2
// B=3 U=4 J=5 ILL=7) and flags unsupported opcodes. Results leave
// through a 2-entry skid buffer (main + skid), so in_ready is a flop.
//
// Parameters: XLEN (32/64, immediate width; 64 enables OP-32/OP-IMM-32),
//             PC_W (PC width, passed through unchanged).
// Ports:
//   clk, rst (async, active-high), flush (drop both entries)
//   in_valid/in_ready/in_inst/in_pc      : IFU side handshake
//   out_valid/out_ready/out_*            : EXU side handshake + decoded fields
// Optional build macro DECODE_PERF_EN adds 64-bit counters perf_decoded
// (output transfers) and perf_stall (cycles with out_valid & !out_ready).
module decode_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic signed [XLEN-1:0] out_imm,
  output logic [2:0]             out_fmt,
  output logic                   out_illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [63:0]            perf_decoded,
  output logic [63:0]            perf_stall
`endif
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_OP       = 7'b0110011, OPC_OP32     = 7'b0111011,
                         OPC_OPIMM    = 7'b0010011, OPC_OPIMM32  = 7'b0011011,
                         OPC_LOAD     = 7'b0000011, OPC_JALR     = 7'b1100111,
                         OPC_MISCMEM  = 7'b0001111, OPC_SYSTEM   = 7'b1110011,
                         OPC_STORE    = 7'b0100011, OPC_BRANCH   = 7'b1100011,
                         OPC_LUI      = 7'b0110111, OPC_AUIPC    = 7'b0010111,
                         OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [PC_W-1:0]        pc;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   illegal;
  } dec_t;

  // Every immediate is first assembled as a 32-bit value sign-extended from
  // inst[31]; this widens it to XLEN keeping the sign.
  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  dec_t dec_p0;
  dec_t main_p1, skid_p1;
  logic vld_p1, skid_vld_p1;
  logic in_xfer, out_xfer, main_free;

  // ---- stage p0: combinational decode of the incoming word ----
  always_comb begin
    dec_p0         = '0;
    dec_p0.pc      = in_pc;
    dec_p0.opcode  = in_inst[6:0];
    dec_p0.funct3  = in_inst[14:12];
    dec_p0.funct7  = in_inst[31:25];
    dec_p0.fmt     = FMT_ILL;
    case (in_inst[6:0])
      OPC_OP:                                   dec_p0.fmt = FMT_R;
      OPC_OP32:    if (XLEN == 64)              dec_p0.fmt = FMT_R;
      OPC_OPIMM, OPC_LOAD, OPC_JALR,
      OPC_MISCMEM, OPC_SYSTEM:                  dec_p0.fmt = FMT_I;
      OPC_OPIMM32: if (XLEN == 64)              dec_p0.fmt = FMT_I;
      OPC_STORE:                                dec_p0.fmt = FMT_S;
      OPC_BRANCH:                               dec_p0.fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                       dec_p0.fmt = FMT_U;
      OPC_JAL:                                  dec_p0.fmt = FMT_J;
      default:                                  dec_p0.fmt = FMT_ILL;
    endcase
    dec_p0.illegal = (dec_p0.fmt == FMT_ILL);
    // Register fields and immediate are only exposed where the format has them.
    case (dec_p0.fmt)
      FMT_R: begin
        dec_p0.rs1 = in_inst[19:15];
        dec_p0.rs2 = in_inst[24:20];
        dec_p0.rd  = in_inst[11:7];
      end
      FMT_I: begin
        dec_p0.rs1 = in_inst[19:15];
        dec_p0.rd  = in_inst[11:7];
        dec_p0.imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
      end
      FMT_S: begin
        dec_p0.rs1 = in_inst[19:15];
        dec_p0.rs2 = in_inst[24:20];
        dec_p0.imm = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
      end
      FMT_B: begin
        dec_p0.rs1 = in_inst[19:15];
        dec_p0.rs2 = in_inst[24:20];
        dec_p0.imm = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0});
      end
      FMT_U: begin
        dec_p0.rd  = in_inst[11:7];
        dec_p0.imm = sext32({in_inst[31:12], 12'b0});
      end
      FMT_J: begin
        dec_p0.rd  = in_inst[11:7];
        dec_p0.imm = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0});
      end
      default: ;
    endcase
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = vld_p1 & out_ready;
  assign main_free = ~vld_p1 | out_xfer;

  // ---- stage p1: main/skid registers ----
  // in_ready always equals !skid_vld_p1, so an input transfer can never
  // coincide with a full skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready    <= 1'b1;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready    <= 1'b1;
    end else if (main_free) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
        in_ready    <= 1'b1;
      end else begin
        vld_p1 <= in_xfer;
        if (in_xfer) main_p1 <= dec_p0;
      end
    end else if (in_xfer) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
      in_ready    <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = main_p1.pc;
  assign out_opcode  = main_p1.opcode;
  assign out_funct3  = main_p1.funct3;
  assign out_funct7  = main_p1.funct7;
  assign out_rs1     = main_p1.rs1;
  assign out_rs2     = main_p1.rs2;
  assign out_rd      = main_p1.rd;
  assign out_imm     = main_p1.imm;
  assign out_fmt     = main_p1.fmt;
  assign out_illegal = main_p1.illegal;

`ifdef DECODE_PERF_EN
  // A transfer in a flush cycle is discarded, so it is not counted as decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_xfer && !flush)     perf_decoded <= perf_decoded + 64'd1;
      if (vld_p1 && !out_ready)   perf_stall   <= perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [63:0] out_imm;

  logic        n_in_ready, n_out_valid, n_out_illegal;
  logic [31:0] n_out_pc;
  logic [6:0]  n_out_opcode, n_out_funct7;
  logic [2:0]  n_out_funct3, n_out_fmt;
  logic [4:0]  n_out_rs1, n_out_rs2, n_out_rd;
  logic [31:0] n_out_imm;
`ifdef DECODE_PERF_EN
  logic [63:0] perf_decoded, perf_stall, n_perf_decoded, n_perf_stall;
`endif

  int compares = 0;
  int mismatches = 0;

  decode_stage #(.XLEN(64), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
`ifdef DECODE_PERF_EN
    , .perf_decoded(perf_decoded), .perf_stall(perf_stall)
`endif
  );

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .out_opcode(n_out_opcode), .out_funct3(n_out_funct3),
    .out_funct7(n_out_funct7), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd),
    .out_imm(n_out_imm), .out_fmt(n_out_fmt), .out_illegal(n_out_illegal)
`ifdef DECODE_PERF_EN
    , .perf_decoded(n_perf_decoded), .perf_stall(n_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    #1 rst = 1'b1;
    #1;
    compares++; if (out_valid !== 1'b0) begin mismatches++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    compares++; if (in_ready !== 1'b1) begin mismatches++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    compares++; if (out_imm !== 64'd0 || out_pc !== 32'd0 || out_fmt !== 3'd0)
      begin mismatches++; $display("FAIL reset_fields: imm %h pc %h fmt %0d want 0", out_imm, out_pc, out_fmt); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_formats();
    vec_t v[9];
    logic [31:0] w;
    v[0] = '{32'hFFF00093, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v[1] = '{32'h0020A423, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 64'd8, 1'b0};
    v[2] = '{32'hFE000EE3, 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    v[3] = '{32'h123452B7, 3'd4, 5'd5, 5'd0, 5'd0, 3'd5, 7'h09, 64'h0000_0000_1234_5000, 1'b0};
    v[4] = '{32'h008000EF, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd8, 1'b0};
    v[5] = '{32'h002081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 64'd0, 1'b0};
    v[6] = '{32'h0000003B, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 1'b0};
    v[7] = '{32'hFE10807F, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h7F, 64'd0, 1'b1};
    v[8] = '{32'h800002B7, 3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      w = v[i].inst;
      in_valid = 1'b1; in_inst = w; in_pc = 32'h1000 + 32'(4 * i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      compares++; if (out_valid !== 1'b1) begin mismatches++; $display("FAIL fmt_valid[%0d]: got %0b want 1", i, out_valid); end
      compares++; if (out_pc !== 32'h1000 + 32'(4 * i)) begin mismatches++; $display("FAIL fmt_pc[%0d]: got %h want %h", i, out_pc, 32'h1000 + 32'(4 * i)); end
      compares++; if (out_opcode !== w[6:0]) begin mismatches++; $display("FAIL fmt_opcode[%0d]: got %h want %h", i, out_opcode, w[6:0]); end
      compares++; if (out_fmt !== v[i].fmt) begin mismatches++; $display("FAIL fmt_fmt[%0d]: got %0d want %0d", i, out_fmt, v[i].fmt); end
      compares++; if (out_illegal !== v[i].ill) begin mismatches++; $display("FAIL fmt_illegal[%0d]: got %0b want %0b", i, out_illegal, v[i].ill); end
      compares++; if ({out_rd, out_rs1, out_rs2} !== {v[i].rd, v[i].rs1, v[i].rs2})
        begin mismatches++; $display("FAIL fmt_regs[%0d]: got rd %0d rs1 %0d rs2 %0d want %0d %0d %0d", i, out_rd, out_rs1, out_rs2, v[i].rd, v[i].rs1, v[i].rs2); end
      compares++; if ({out_funct3, out_funct7} !== {v[i].f3, v[i].f7})
        begin mismatches++; $display("FAIL fmt_funct[%0d]: got f3 %0d f7 %h want %0d %h", i, out_funct3, out_funct7, v[i].f3, v[i].f7); end
      compares++; if (out_imm !== v[i].imm) begin mismatches++; $display("FAIL fmt_imm[%0d]: got %h want %h", i, out_imm, v[i].imm); end
    end
    @(posedge clk); #1;
    compares++; if (out_valid !== 1'b0) begin mismatches++; $display("FAIL fmt_drain: out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_xlen32();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h0000003B; in_pc = 32'h2000;
    @(posedge clk); #1;
    compares++; if (n_out_illegal !== 1'b1 || n_out_fmt !== 3'd7)
      begin mismatches++; $display("FAIL x32_op32_class: illegal %0b fmt %0d want 1 7", n_out_illegal, n_out_fmt); end
    compares++; if (n_out_imm !== 32'd0 || n_out_rd !== 5'd0)
      begin mismatches++; $display("FAIL x32_op32_fields: imm %h rd %0d want 0 0", n_out_imm, n_out_rd); end
    in_inst = 32'hFFF00093; in_pc = 32'h2004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    compares++; if (n_out_imm !== 32'hFFFF_FFFF || n_out_fmt !== 3'd1 || n_out_rd !== 5'd1)
      begin mismatches++; $display("FAIL x32_addi: imm %h fmt %0d rd %0d want ffffffff 1 1", n_out_imm, n_out_fmt, n_out_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs[4];
    int sent, got;
    logic doin, doout;
    for (int i = 0; i < 4; i++) pcs[i] = 32'h3000 + 32'(16 * i);
    sent = 0; got = 0;
    in_valid = 1'b1; in_inst = (32'(0) << 20) | (32'(1) << 7) | 32'h13; in_pc = pcs[0];
    out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 2) begin
        compares++; if (in_ready !== 1'b0) begin mismatches++; $display("FAIL b2b_in_ready_low: got %0b want 0", in_ready); end
        compares++; if (out_valid !== 1'b1 || out_pc !== pcs[0])
          begin mismatches++; $display("FAIL b2b_hold: valid %0b pc %h want 1 %h", out_valid, out_pc, pcs[0]); end
      end
      doin = in_valid && in_ready;
      doout = out_valid && out_ready;
      if (doout) begin
        compares++;
        if (got >= 4) begin mismatches++; $display("FAIL b2b_extra: got output pc %h after 4", out_pc); end
        else if (out_pc !== pcs[got] || out_rd !== 5'(got + 1) || out_imm !== 64'(got))
          begin mismatches++; $display("FAIL b2b_order[%0d]: pc %h rd %0d imm %0d want %h %0d %0d", got, out_pc, out_rd, out_imm, pcs[got], got + 1, got); end
        got++;
      end
      @(posedge clk); #1;
      if (doin) begin
        sent++;
        if (sent < 4) begin
          in_inst = (32'(sent) << 20) | (32'(sent + 1) << 7) | 32'h13;
          in_pc = pcs[sent];
        end else in_valid = 1'b0;
      end
      out_ready = (c >= 4);
    end
    in_valid = 1'b0;
    compares++; if (got != 4 || sent != 4) begin mismatches++; $display("FAIL b2b_count: got %0d sent %0d want 4 4", got, sent); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h300;
    @(posedge clk); #1;
    in_pc = 32'h304;
    @(posedge clk); #1;
    compares++; if (in_ready !== 1'b0) begin mismatches++; $display("FAIL flush_pre_full: in_ready %0b want 0", in_ready); end
    flush = 1'b1; in_pc = 32'h308;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    compares++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin mismatches++; $display("FAIL flush_full: valid %0b in_ready %0b want 0 1", out_valid, in_ready); end
    @(posedge clk); #1;
    compares++; if (out_valid !== 1'b0) begin mismatches++; $display("FAIL flush_stays_empty: valid %0b want 0", out_valid); end
    // flush while in_ready=1: the presented input must be dropped too
    in_valid = 1'b1; in_pc = 32'h30C;
    @(posedge clk); #1;
    flush = 1'b1; in_pc = 32'h310;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    compares++; if (out_valid !== 1'b0) begin mismatches++; $display("FAIL flush_drop_input: valid %0b pc %h want 0", out_valid, out_pc); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 32'h314;
    @(posedge clk); #1;
    in_valid = 1'b0;
    compares++; if (out_valid !== 1'b1 || out_pc !== 32'h314 || out_rd !== 5'd5 || out_imm !== 64'h12345000)
      begin mismatches++; $display("FAIL flush_after: valid %0b pc %h rd %0d imm %h want 1 314 5 12345000", out_valid, out_pc, out_rd, out_imm); end
    @(posedge clk); #1;
`ifdef DECODE_PERF_EN
    compares++; if (perf_decoded !== 64'd16) begin mismatches++; $display("FAIL perf_decoded: got %0d want 16", perf_decoded); end
    compares++; if (perf_stall !== 64'd7) begin mismatches++; $display("FAIL perf_stall: got %0d want 7", perf_stall); end
`endif
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h400;
    @(posedge clk); #1;
    in_valid = 1'b0;
    compares++; if (out_valid !== 1'b1) begin mismatches++; $display("FAIL areset_pre: valid %0b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    compares++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0)
      begin mismatches++; $display("FAIL areset_immediate: valid %0b in_ready %0b pc %h want 0 1 0", out_valid, in_ready, out_pc); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    compares++; if (out_valid !== 1'b0) begin mismatches++; $display("FAIL areset_after: valid %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen32();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end
endmodule
